// File: rtl/kernel_channel_psum_buf_if.sv
// Bus bundle for the partial-sum buffer: psum replay to the PE array, psum capture from the
// array, and the final-sum output stream.
interface kernel_channel_psum_buf_if #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4
);
    localparam int W = BIT_WIDTH * NUM_KERNEL;

    // Handshakes: i_psum_req is a one-cycle request answered by o_psum_val one cycle later
    // (or never, if rejected); a word is captured only when every bit of i_psum_val is set;
    // an o_out beat transfers on a cycle where o_out_val and i_out_rdy are both high, and
    // o_out is held stable while o_out_val is high and i_out_rdy is low.
    logic                  i_psum_req;
    logic [W-1:0]          o_psum;
    logic                  o_psum_val;
    logic [W-1:0]          i_psum;
    logic [NUM_KERNEL-1:0] i_psum_val;
    logic [W-1:0]          o_out;
    logic                  o_out_val;
    logic                  i_out_rdy;

    modport master (
        output i_psum_req, i_psum, i_psum_val, i_out_rdy,
        input  o_psum, o_psum_val, o_out, o_out_val
    );

    modport slave (
        input  i_psum_req, i_psum, i_psum_val, i_out_rdy,
        output o_psum, o_psum_val, o_out, o_out_val
    );
endinterface

// File: rtl/kernel_channel_psum_buf.sv
// Partial-sum return buffer: replays stored psums to the PE array each channel-group pass,
// then drains the final sums. Optional macro PSUM_BUF_RELU_EN applies ReLU to drained lanes.
module kernel_channel_psum_buf #(
    parameter int BIT_WIDTH  = 8,
    parameter int NUM_KERNEL = 4,
    parameter int NUM_PIXEL  = 16,
    parameter int REG_WIDTH  = 32,
    localparam int ADDR_WIDTH = $clog2(NUM_PIXEL)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_start,
    input  logic [7:0]             i_num_pass,
    input  logic [ADDR_WIDTH:0]    i_num_pixel,
    kernel_channel_psum_buf_if.slave bus,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [REG_WIDTH-1:0]   err_psum_val,
    output logic [1:0]             dbg_state
);
    localparam int W     = BIT_WIDTH * NUM_KERNEL;
    localparam int TOT_W = 8 + ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH:0] MAX_PIX = (ADDR_WIDTH + 1)'(NUM_PIXEL);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                 state;
    logic [W-1:0]           ram [NUM_PIXEL];
    logic [ADDR_WIDTH:0]    num_pix;
    logic [TOT_W-1:0]       tot_words, rd_total, wr_total, num_pix_ext;
    logic [ADDR_WIDTH-1:0]  rd_addr, wr_addr, drain_addr, last_addr;
    logic [4:0]             err_q, err_set;
    logic [ADDR_WIDTH:0]    cfg_pix;
    logic [7:0]             cfg_pass;
    logic in_accum, rd_done, rd_ovt, rd_ok, wr_full, wr_part, wr_ok, last_wr, out_hs, last_beat;

    function automatic logic [W-1:0] relu(input logic [W-1:0] w);
`ifdef PSUM_BUF_RELU_EN
        logic [W-1:0] r;
        r = w;
        for (int k = 0; k < NUM_KERNEL; k++)
            if (w[BIT_WIDTH*(k+1)-1]) r[BIT_WIDTH*k +: BIT_WIDTH] = '0;
        return r;
`else
        return w;
`endif
    endfunction

    assign cfg_pix  = (i_num_pixel == '0 || i_num_pixel > MAX_PIX) ? MAX_PIX : i_num_pixel;
    assign cfg_pass = (i_num_pass == 8'd0) ? 8'd1 : i_num_pass;

    assign num_pix_ext = TOT_W'(num_pix);
    assign last_addr   = ADDR_WIDTH'(num_pix - 1'b1);
    assign in_accum    = (state == ACCUM);

    // A read may run at most one pass ahead of the writes, so its address never meets a live write.
    assign rd_done   = (rd_total == tot_words);
    assign rd_ovt    = (rd_total >= wr_total + num_pix_ext);
    assign rd_ok     = in_accum & bus.i_psum_req & ~rd_done & ~rd_ovt;
    assign wr_full   = &bus.i_psum_val;
    assign wr_part   = (|bus.i_psum_val) & ~wr_full;
    assign wr_ok     = in_accum & wr_full;
    assign last_wr   = wr_ok & (wr_total == tot_words - 1'b1);
    assign out_hs    = (state == DRAIN) & bus.o_out_val & bus.i_out_rdy;
    assign last_beat = out_hs & (drain_addr == last_addr);

    always_comb begin
        err_set = '0;
        if (in_accum) begin
            err_set[0] = wr_part;
            err_set[1] = bus.i_psum_req & rd_ovt;
            err_set[2] = bus.i_psum_req & rd_done;
        end else begin
            err_set[2] = bus.i_psum_req;
            err_set[3] = |bus.i_psum_val;
        end
        err_set[4] = i_start & (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (wr_ok && !rst) ram[wr_addr] <= bus.i_psum;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            num_pix        <= '0;
            tot_words      <= '0;
            rd_total       <= '0;
            wr_total       <= '0;
            rd_addr        <= '0;
            wr_addr        <= '0;
            drain_addr     <= '0;
            err_q          <= '0;
            o_done         <= 1'b0;
            bus.o_psum     <= '0;
            bus.o_psum_val <= 1'b0;
            bus.o_out      <= '0;
            bus.o_out_val  <= 1'b0;
        end else begin
            bus.o_psum_val <= rd_ok;
            o_done         <= 1'b0;
            err_q          <= (((state == IDLE) && i_start) ? '0 : err_q) | err_set;

            if (rd_ok) begin
                bus.o_psum <= (rd_total < num_pix_ext) ? '0 : ram[rd_addr];
                rd_total   <= rd_total + 1'b1;
                rd_addr    <= (rd_addr == last_addr) ? '0 : rd_addr + 1'b1;
            end
            if (wr_ok) begin
                wr_total <= wr_total + 1'b1;
                wr_addr  <= (wr_addr == last_addr) ? '0 : wr_addr + 1'b1;
            end

            case (state)
                IDLE: if (i_start) begin
                    state     <= ACCUM;
                    num_pix   <= cfg_pix;
                    tot_words <= TOT_W'(cfg_pass) * TOT_W'(cfg_pix);
                    rd_total  <= '0;
                    wr_total  <= '0;
                    rd_addr   <= '0;
                    wr_addr   <= '0;
                end
                ACCUM: if (last_wr) begin
                    state         <= DRAIN;
                    drain_addr    <= '0;
                    bus.o_out_val <= 1'b1;
                    // Single-pixel jobs write address 0 on this very edge: forward it.
                    bus.o_out     <= relu((wr_addr == '0) ? bus.i_psum : ram[0]);
                end
                DRAIN: if (out_hs) begin
                    if (last_beat) begin
                        state         <= IDLE;
                        bus.o_out_val <= 1'b0;
                        bus.o_out     <= '0;
                        o_done        <= 1'b1;
                    end else begin
                        drain_addr <= drain_addr + 1'b1;
                        bus.o_out  <= relu(ram[drain_addr + 1'b1]);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy       = (state != IDLE);
    assign dbg_state    = state;
    assign err_psum_val = {{(REG_WIDTH-5){1'b0}}, err_q};
endmodule
